// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined mips core: stretched clock-aligned core reset,
// free-run / single-step clock enable, and executed-cycle counting with a run-length limit.
module mips_run_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned RUN_CYCLES  = 9,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    input  logic             step_mode,
    input  logic             step,
    output logic             core_reset,
    output logic             core_run,
    output logic [CNT_W-1:0] cycle_count,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam int unsigned      HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam bit               LIMITED   = (RUN_CYCLES != 0);
    localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(LIMITED ? (RUN_CYCLES - 1) : 32'd0);
    localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(RUN_CYCLES);

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycle_count_q, cycle_count_d;
    logic              core_reset_q, core_reset_d;
    logic              done_q, done_d;
    logic              run_en;

    always_comb begin
        // restart suppresses the enable combinationally so the core never executes on that cycle
        run_en        = !restart && ((state_q == S_RUN) || ((state_q == S_PAUSE) && step));
        state_d       = state_q;
        hold_cnt_d    = hold_cnt_q;
        cycle_count_d = cycle_count_q;
        core_reset_d  = core_reset_q;
        done_d        = done_q;

        if (restart) begin
            state_d       = S_HOLD;
            hold_cnt_d    = '0;
            cycle_count_d = '0;
            core_reset_d  = 1'b1;
            done_d        = 1'b0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_d      = step_mode ? S_PAUSE : S_RUN;
                        hold_cnt_d   = '0;
                        core_reset_d = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                S_RUN, S_PAUSE: begin
                    if ((state_q == S_RUN) && step_mode) begin
                        state_d = S_PAUSE;
                    end else if ((state_q == S_PAUSE) && !step_mode) begin
                        state_d = S_RUN;
                    end
                    // Limit check comes last so reaching the run length overrides a mode change
                    if (run_en) begin
                        if (LIMITED && (cycle_count_q == RUN_LAST)) begin
                            cycle_count_d = RUN_LIMIT;
                            state_d       = S_DONE;
                            done_d        = 1'b1;
                        end else begin
                            cycle_count_d = cycle_count_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_HOLD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_HOLD;
            hold_cnt_q    <= '0;
            cycle_count_q <= '0;
            core_reset_q  <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            cycle_count_q <= cycle_count_d;
            core_reset_q  <= core_reset_d;
            done_q        <= done_d;
        end
    end

    assign core_reset  = core_reset_q;
    assign core_run    = run_en;
    assign cycle_count = cycle_count_q;
    assign done        = done_q;
    assign state       = state_q;

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
Run controller sitting between the board/bench clock-reset source and the pipelined mips core. Converts the raw asynchronous active-low system reset into a stretched, clock-aligned active-high core reset. Gates core execution through a clock-enable, with free-run and single-step modes. Counts executed core cycles and raises done after a programmed run length, replacing fixed-length bench run windows.

Parameters:
HOLD_CYCLES, 4, core_reset stays high for this many clk cycles after reset release or restart (min 1)
RUN_CYCLES, 9, executed core cycles before done; 0 = unlimited
CNT_W, 16, width of cycle_count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low system reset
restart  input  1  sync pulse; re-enter reset hold, clear counters
step_mode  input  1  1 = single-step, 0 = free run
step  input  1  sync pulse; one core cycle when paused
core_reset  output  1  active-high reset to mips core, registered
core_run  output  1  clock-enable to mips core, combinational from state/step
cycle_count  output  CNT_W  number of cycles with core_run=1 since last hold
done  output  1  run length reached, registered
state  output  2  HOLD=0, RUN=1, PAUSE=2, DONE=3

Behaviour:
- Async reset (reset=0): state=HOLD, hold_cnt=0, core_reset=1, cycle_count=0, done=0, core_run=0. Takes effect immediately, mid-run included.
- HOLD: core_reset=1, core_run=0, hold_cnt++ each cycle. When hold_cnt==HOLD_CYCLES-1: next state RUN if step_mode=0, else PAUSE. core_reset is 0 from the first RUN/PAUSE cycle.
- Result: with HOLD_CYCLES=4, core_reset is high for exactly 4 rising edges after reset release.
- RUN: core_run=1.
  - step_mode=1 sampled → PAUSE next cycle. The current cycle still executes.
- PAUSE: core_run = step (single-cycle enable per step pulse). step held high = one core cycle per clk.
  - step_mode=0 → RUN next cycle.
- Counting: cycle_count increments on every edge where core_run=1.
  - RUN_CYCLES≠0: when core_run=1 and cycle_count==RUN_CYCLES-1, cycle_count becomes RUN_CYCLES and state → DONE. done=1 from that next cycle.
  - RUN_CYCLES=0: never DONE; cycle_count wraps from 2^CNT_W-1 to 0.
- DONE: core_run=0, core_reset=0, done=1, cycle_count frozen. step and step_mode are ignored. Exit only via restart or reset.
- restart: sampled in any state → HOLD, hold_cnt=0, cycle_count=0, done=0, core_reset=1 next cycle. The current cycle's core_run is forced 0.
- Priority per cycle: reset > restart > run-length limit > step_mode change. If the limit is reached on a cycle where step_mode=1, DONE wins.
- No other outputs are affected by step outside PAUSE.

Test Plan:
1. Reset low 2 cycles then high, step_mode=0, defaults → core_reset high 4 edges; core_run high 9 consecutive cycles; cycle_count=9; done=1; state=3 held.
2. step_mode=1 from reset, three step pulses spaced 3 cycles apart → state=2 after hold; core_run high exactly 3 single cycles; cycle_count=3; done=0.
3. Free run, assert step_mode after cycle_count=5, then release after 4 idle cycles → cycle_count stays 6 during pause; resumes to 9; done=1.
4. restart pulse at cycle_count=7 → core_run=0 that cycle; core_reset high 4 edges; cycle_count=0; full 9-cycle run repeats.
5. reset low mid-RUN at cycle_count=4 → immediately core_reset=1, core_run=0, cycle_count=0, state=0, without waiting for a clk edge.
6. RUN_CYCLES=0, CNT_W=4, free run 20 cycles → never done; cycle_count wraps 15→0, reads 4 at the end.
